// File: rtl/action_encoder.sv
// Player action producer: debounces six raw buttons, priority-encodes new presses
// into a one-hot action, and holds it until the board's turn strobe consumes it.
module action_encoder #(
    parameter int DBNC_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    input  logic       turn,
    output logic [5:0] act,
    output logic       act_vld,
    output logic       drop
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYC - 1);

    typedef enum logic {
        EMPTY,
        HELD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt [6];
    logic [5:0]       stable_p0;
    logic [5:0]       stable_p1;
    logic [5:0]       press;
    logic [5:0]       winner;
    logic             losers;

    // Highest set bit wins: jump > kick > punch > wait > move forward > move back.
    function automatic logic [5:0] pick_winner(input logic [5:0] req);
        logic [5:0] w;
        w = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            if (req[i]) begin
                w = 6'b000001 << i;
            end
        end
        return w;
    endfunction

    // Debounce stage: each bit flips only after DBNC_CYC consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                cnt[i] <= '0;
            end
            stable_p0 <= '0;
            stable_p1 <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (btn[i] != stable_p0[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        stable_p0[i] <= btn[i];
                        cnt[i]       <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
            stable_p1 <= stable_p0;
        end
    end

    always_comb begin
        press  = stable_p0 & ~stable_p1;
        winner = pick_winner(press);
        losers = |(press & ~winner);
    end

    // Action stage: latch the winning press and hold it until a turn consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            act     <= '0;
            act_vld <= 1'b0;
            drop    <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                EMPTY: begin
                    if (|press) begin
                        state   <= HELD;
                        act     <= winner;
                        act_vld <= 1'b1;
                        drop    <= losers;
                    end else begin
                        act     <= '0;
                        act_vld <= 1'b0;
                    end
                end
                HELD: begin
                    if (turn) begin
                        if (|press) begin
                            act     <= winner;
                            act_vld <= 1'b1;
                            drop    <= losers;
                        end else begin
                            state   <= EMPTY;
                            act     <= '0;
                            act_vld <= 1'b0;
                        end
                    end else begin
                        // First press wins; anything arriving while held is discarded.
                        drop <= |press;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    act     <= '0;
                    act_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_encoder.sv
// Directed bench for action_encoder with DBNC_CYC=4: debounce latency, glitch rejection,
// priority, drop pulses, turn handling and reset while held.
module tb_action_encoder;

    logic       clk;
    logic       rst;
    logic [5:0] btn;
    logic       turn;
    logic [5:0] act;
    logic       act_vld;
    logic       drop;

    int vectors    = 0;
    int miscompares = 0;

    action_encoder #(.DBNC_CYC(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .turn    (turn),
        .act     (act),
        .act_vld (act_vld),
        .drop    (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] e_act, input logic e_vld,
                           input logic e_drop);
        chk({tag, ".act"},  {2'b00, act},     {2'b00, e_act});
        chk({tag, ".vld"},  {7'd0, act_vld},  {7'd0, e_vld});
        chk({tag, ".drop"}, {7'd0, drop},     {7'd0, e_drop});
    endtask

    initial begin
        rst  = 1'b1;
        btn  = 6'b000000;
        turn = 1'b0;
        tick(2);
        chk_out("reset", 6'b000000, 1'b0, 1'b0);

        // Move forward held from edge 0: accepted after edge 4.
        rst = 1'b0;
        btn = 6'b000010;
        tick(4);
        chk_out("mf_pre", 6'b000000, 1'b0, 1'b0);
        tick(1);
        chk_out("mf_latch", 6'b000010, 1'b1, 1'b0);
        tick(3);
        chk_out("mf_hold", 6'b000010, 1'b1, 1'b0);
        turn = 1'b1;
        tick(1);
        turn = 1'b0;
        chk_out("mf_turn", 6'b000000, 1'b0, 1'b0);
        btn = 6'b000000;
        tick(6);
        chk_out("mf_release", 6'b000000, 1'b0, 1'b0);

        // Turn while empty: nothing delivered, stays empty.
        turn = 1'b1;
        tick(1);
        turn = 1'b0;
        chk_out("empty_turn", 6'b000000, 1'b0, 1'b0);

        // Punch glitch of 3 edges is rejected.
        btn = 6'b001000;
        tick(3);
        btn = 6'b000000;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk_out("glitch", 6'b000000, 1'b0, 1'b0);
        end

        // Jump and kick together: jump wins, one drop pulse.
        btn = 6'b110000;
        tick(4);
        chk_out("jk_pre", 6'b000000, 1'b0, 1'b0);
        tick(1);
        chk_out("jk_latch", 6'b100000, 1'b1, 1'b1);
        tick(1);
        chk_out("jk_after", 6'b100000, 1'b1, 1'b0);
        turn = 1'b1;
        tick(1);
        turn = 1'b0;
        chk_out("jk_turn", 6'b000000, 1'b0, 1'b0);
        btn = 6'b000000;
        tick(6);

        // Held kick, then punch pressed without turn: punch dropped.
        btn = 6'b010000;
        tick(5);
        chk_out("kick_latch", 6'b010000, 1'b1, 1'b0);
        btn = 6'b011000;
        tick(4);
        chk_out("kp_pre", 6'b010000, 1'b1, 1'b0);
        tick(1);
        chk_out("kp_drop", 6'b010000, 1'b1, 1'b1);
        tick(1);
        chk_out("kp_after", 6'b010000, 1'b1, 1'b0);
        turn = 1'b1;
        tick(1);
        turn = 1'b0;
        chk_out("kp_turn", 6'b000000, 1'b0, 1'b0);
        btn = 6'b000000;
        tick(6);

        // Held move forward; punch press coincides with turn: punch replaces it.
        btn = 6'b000010;
        tick(5);
        chk_out("mfp_latch", 6'b000010, 1'b1, 1'b0);
        btn = 6'b001010;
        tick(4);
        chk_out("mfp_pre", 6'b000010, 1'b1, 1'b0);
        turn = 1'b1;
        tick(1);
        turn = 1'b0;
        chk_out("mfp_swap", 6'b001000, 1'b1, 1'b0);
        tick(1);
        chk_out("mfp_hold", 6'b001000, 1'b1, 1'b0);
        turn = 1'b1;
        tick(1);
        turn = 1'b0;
        chk_out("mfp_turn", 6'b000000, 1'b0, 1'b0);
        btn = 6'b000000;
        tick(6);

        // Reset while holding wait with the button still down.
        btn = 6'b000100;
        tick(5);
        chk_out("wait_latch", 6'b000100, 1'b1, 1'b0);
        rst = 1'b1;
        tick(1);
        chk_out("wait_rst", 6'b000000, 1'b0, 1'b0);
        rst = 1'b0;
        tick(4);
        chk_out("wait_pre", 6'b000000, 1'b0, 1'b0);
        tick(1);
        chk_out("wait_relatch", 6'b000100, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
